// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter sharing one single-port 256x8 synchronous data RAM among
// ncores processor cores. Each access runs Idle -> Mem -> Read -> Done, so one
// access completes at most every four cycles.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rden        per-core read request (level)
//   wren        per-core write request (level); wins over rden for the same core
//   Address     per-core 16-bit address, core i at [16i+15:16i], low byte used
//   Din         per-core 16-bit write data, core i at [16i+15:16i], low byte used
//   RAMq        RAM read data, valid the cycle after the RAM samples its address
//   acq         one-hot completion pulse, one cycle wide
//   gnt         one-hot grant, high while the access is in flight
//   Dq          last read result, {8'h00, RAMq}
//   RAMAddress  registered RAM address
//   RAMDin      registered RAM write data
//   RAMwren     registered RAM write enable
module dmem_arbiter #(
    parameter int unsigned ncores = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ncores-1:0]      rden,
    input  logic [ncores-1:0]      wren,
    input  logic [16*ncores-1:0]   Address,
    input  logic [16*ncores-1:0]   Din,
    input  logic [7:0]             RAMq,
    output logic [ncores-1:0]      acq,
    output logic [ncores-1:0]      gnt,
    output logic [15:0]            Dq,
    output logic [7:0]             RAMAddress,
    output logic [7:0]             RAMDin,
    output logic                   RAMwren
);

    localparam int unsigned IdxW = (ncores > 1) ? $clog2(ncores) : 1;

    typedef enum logic [1:0] {StIdle, StMem, StRead, StDone} state_e;

    state_e          state_q;
    logic [IdxW-1:0] last_q;   // core served most recently
    logic [IdxW-1:0] gidx_q;   // core currently granted
    logic            wr_q;     // access in flight is a write

    logic [ncores-1:0] pending;
    logic              any_pending;
    logic [IdxW-1:0]   win_idx;
    logic [ncores-1:0] win_oh;
    logic [7:0]        win_addr;
    logic [7:0]        win_din;
    logic              win_wr;
    int unsigned       cand;
    logic [IdxW-1:0]   cand_idx;

    assign pending = rden | wren;

    // Search from last+1 upward, wrapping; the first pending core wins.
    always_comb begin
        any_pending = 1'b0;
        win_idx     = '0;
        win_oh      = '0;
        win_addr    = 8'h00;
        win_din     = 8'h00;
        win_wr      = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned i = 1; i <= ncores; i++) begin
            cand     = (32'(last_q) + i) % ncores;
            cand_idx = IdxW'(cand);
            if (!any_pending && pending[cand_idx]) begin
                any_pending      = 1'b1;
                win_idx          = cand_idx;
                win_oh[cand_idx] = 1'b1;
                win_addr         = 8'(Address >> (16 * cand));
                win_din          = 8'(Din >> (16 * cand));
                win_wr           = wren[cand_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_q     <= IdxW'(ncores - 1);
            gidx_q     <= '0;
            wr_q       <= 1'b0;
            acq        <= '0;
            gnt        <= '0;
            Dq         <= 16'h0000;
            RAMAddress <= 8'h00;
            RAMDin     <= 8'h00;
            RAMwren    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Address, data and direction are captured only here.
                    if (any_pending) begin
                        RAMAddress <= win_addr;
                        RAMDin     <= win_din;
                        RAMwren    <= win_wr;
                        wr_q       <= win_wr;
                        gnt        <= win_oh;
                        gidx_q     <= win_idx;
                        state_q    <= StMem;
                    end
                end
                StMem: begin
                    // RAM samples address/data/enable at the end of this cycle.
                    RAMwren <= 1'b0;
                    state_q <= StRead;
                end
                StRead: begin
                    if (!wr_q) begin
                        Dq <= {8'h00, RAMq};
                    end
                    acq     <= gnt;
                    state_q <= StDone;
                end
                StDone: begin
                    acq     <= '0;
                    gnt     <= '0;
                    last_q  <= gidx_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter (ncores = 2) with a behavioural 256x8 synchronous
// RAM attached to the RAM port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rden, wren;
    logic [31:0] Address, Din;
    logic [7:0]  RAMq;
    logic [1:0]  acq, gnt;
    logic [15:0] Dq;
    logic [7:0]  RAMAddress, RAMDin;
    logic        RAMwren;

    logic [7:0]  mem [256];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dmem_arbiter #(.ncores(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rden       (rden),
        .wren       (wren),
        .Address    (Address),
        .Din        (Din),
        .RAMq       (RAMq),
        .acq        (acq),
        .gnt        (gnt),
        .Dq         (Dq),
        .RAMAddress (RAMAddress),
        .RAMDin     (RAMDin),
        .RAMwren    (RAMwren)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM.
    always @(posedge clk) begin
        if (RAMwren) mem[RAMAddress] <= RAMDin;
        RAMq <= mem[RAMAddress];
    end

    typedef struct {
        logic [1:0]  rden;
        logic [1:0]  wren;
        logic [15:0] a0, a1, d0, d1;
        logic [1:0]  e_gnt;
        logic [7:0]  e_addr;
        logic [7:0]  e_din;
        logic        e_wr;
        logic [15:0] e_dq;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int   prev_cyc;
        int   waited;
        logic [1:0] exp_acq;
        logic [15:0] exp_dq;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h3C] = 8'hA5;
        mem[8'h10] = 8'hEE;
        mem[8'h20] = 8'h11;
        mem[8'h01] = 8'h99;
        RAMq    = 8'h00;
        rden    = '0;
        wren    = '0;
        Address = '0;
        Din     = '0;

        //          rden   wren   a0       a1       d0       d1       gnt    addr   din    wr    dq
        vecs[0] = '{2'b01, 2'b00, 16'h123C, 16'h0000, 16'h0000, 16'h0000, 2'b01, 8'h3C, 8'h00, 1'b0, 16'h00A5};
        vecs[1] = '{2'b00, 2'b10, 16'h0000, 16'h0010, 16'h0000, 16'hFF5A, 2'b10, 8'h10, 8'h5A, 1'b1, 16'h00A5};
        vecs[2] = '{2'b10, 2'b00, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 2'b10, 8'h10, 8'h00, 1'b0, 16'h005A};
        vecs[3] = '{2'b01, 2'b01, 16'h0020, 16'h0000, 16'h0077, 16'h0000, 2'b01, 8'h20, 8'h77, 1'b1, 16'h005A};
        vecs[4] = '{2'b10, 2'b00, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 2'b10, 8'h20, 8'h00, 1'b0, 16'h0077};
        vecs[5] = '{2'b11, 2'b00, 16'h003C, 16'h0010, 16'h0000, 16'h0000, 2'b01, 8'h3C, 8'h00, 1'b0, 16'h00A5};
        vecs[6] = '{2'b11, 2'b00, 16'h003C, 16'h0010, 16'h0000, 16'h0000, 2'b10, 8'h10, 8'h00, 1'b0, 16'h005A};
        vecs[7] = '{2'b00, 2'b01, 16'hFF01, 16'h0000, 16'hAB33, 16'h0000, 2'b01, 8'h01, 8'h33, 1'b1, 16'h005A};
        vecs[8] = '{2'b01, 2'b00, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'b01, 8'h01, 8'h00, 1'b0, 16'h0033};

        // Reset for two cycles, then idle with no requests.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("reset_idle%0d", i),
                {27'b0, acq, gnt, Dq, RAMAddress, RAMDin, RAMwren}, 64'h0);
        end

        // Table-driven single transactions; requests drop after capture.
        for (int v = 0; v < 9; v++) begin
            rden    = vecs[v].rden;
            wren    = vecs[v].wren;
            Address = {vecs[v].a1, vecs[v].a0};
            Din     = {vecs[v].d1, vecs[v].d0};
            tick();
            chk($sformatf("v%0d_gnt", v), 64'(gnt), 64'(vecs[v].e_gnt));
            chk($sformatf("v%0d_addr", v), 64'(RAMAddress), 64'(vecs[v].e_addr));
            chk($sformatf("v%0d_din", v), 64'(RAMDin), 64'(vecs[v].e_din));
            chk($sformatf("v%0d_wren_on", v), 64'(RAMwren), 64'(vecs[v].e_wr));
            chk($sformatf("v%0d_acq_early", v), 64'(acq), 64'h0);
            rden = '0;
            wren = '0;
            Address = '0;
            Din = '0;
            tick();
            chk($sformatf("v%0d_wren_off", v), 64'(RAMwren), 64'h0);
            chk($sformatf("v%0d_acq_early2", v), 64'(acq), 64'h0);
            tick();
            chk($sformatf("v%0d_acq", v), 64'(acq), 64'(vecs[v].e_gnt));
            chk($sformatf("v%0d_dq", v), 64'(Dq), 64'(vecs[v].e_dq));
            tick();
            chk($sformatf("v%0d_acq_end", v), 64'(acq), 64'h0);
            chk($sformatf("v%0d_gnt_end", v), 64'(gnt), 64'h0);
        end

        // Reset while core 1's read is in the Read state.
        rden    = 2'b10;
        Address = {16'h003C, 16'h0000};
        tick();
        chk("rstmid_gnt", 64'(gnt), 64'h2);
        rden = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_acq", 64'(acq), 64'h0);
        chk("rstmid_gnt0", 64'(gnt), 64'h0);
        chk("rstmid_dq", 64'(Dq), 64'h0);
        tick();
        chk("rstmid_acq_late", 64'(acq), 64'h0);

        // Contention: both cores read continuously; core 0 must win first.
        rden     = 2'b11;
        Address  = {16'h0010, 16'h003C};
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (acq == 2'b00 && waited < 8) begin
                tick();
                waited++;
            end
            exp_acq = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_dq  = (k % 2 == 0) ? 16'h00A5 : 16'h005A;
            chk($sformatf("cont%0d_acq", k), 64'(acq), 64'(exp_acq));
            chk($sformatf("cont%0d_dq", k), 64'(Dq), 64'(exp_dq));
            if (k > 0) chk($sformatf("cont%0d_gap", k), 64'(cyc - prev_cyc), 64'd4);
            prev_cyc = cyc;
            if (k == 3) rden = '0;
            tick();
        end
        for (int i = 0; i < 6; i++) tick();
        chk("cont_quiet_gnt", 64'(gnt), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
